// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and helpers for sync_fifo_level: the sticky
//               error-flag struct and the level threshold compare.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Sticky error flags reported by the FIFO.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Unsigned "a >= b" on occupancy values; used for both threshold flags
  // (almost-empty swaps the operands).
  function automatic logic level_ge(input int unsigned a, input int unsigned b);
    return (a >= b);
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : FIFO storage array, one synchronous write port and one
//               asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
  parameter int BITS = 32,
  parameter int SIZE = 16,
  localparam int AW  = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [BITS-1:0] rd_data
);

  logic [BITS-1:0] r_mem [SIZE];

  // Storage write; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo_level.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_level
// Description : Single-clock FIFO with occupancy output, almost-full /
//               almost-empty thresholds and sticky overflow/underflow flags.
//               Define SYNC_FIFO_LEVEL_FWFT_EN for first-word-fall-through
//               read mode; otherwise read data arrives one cycle after an
//               accepted read.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_level
  import fifo_pkg::*;
#(
  parameter int BITS = 32,
  parameter int SIZE = 16,
  localparam int LVL = $clog2(SIZE) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p_write_en,
  input  logic [BITS-1:0] p_write_data,
  output logic            p_write_full,
  output logic            p_write_almost_full,
  input  logic [LVL-1:0]  p_af_thresh,
  input  logic            p_read_en,
  output logic [BITS-1:0] p_read_data,
  output logic            p_read_empty,
  output logic            p_read_almost_empty,
  input  logic [LVL-1:0]  p_ae_thresh,
  output logic [LVL-1:0]  p_level,
  output logic            p_overflow,
  output logic            p_underflow,
  input  logic            p_err_clear
);

  localparam int AW = $clog2(SIZE);
  localparam logic [LVL-1:0] c_full_lvl = LVL'(SIZE);
  localparam logic [LVL-1:0] c_one_lvl  = LVL'(1);

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LVL-1:0]  r_level;
  logic [BITS-1:0] r_rd_data;
  fifo_err_t       r_err;

  logic            w_full;
  logic            w_empty;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_mem_we;
  logic [BITS-1:0] w_mem_rd_data;

  assign w_full   = (r_level == c_full_lvl);
  assign w_wr_acc = p_write_en && !w_full;
  assign w_rd_acc = p_read_en && !w_empty;

  fifo_mem #(
    .BITS (BITS),
    .SIZE (SIZE)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_mem_we),
    .wr_addr (r_wr_ptr),
    .wr_data (p_write_data),
    .rd_addr (r_rd_ptr),
    .rd_data (w_mem_rd_data)
  );

  // Write pointer follows every entry that lands in the storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_mem_we) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
    end
  end

  // Occupancy counter; a simultaneous read and write leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      r_level <= r_level + c_one_lvl;
    end else if (w_rd_acc && !w_wr_acc) begin
      r_level <= r_level - c_one_lvl;
    end
  end

  // Sticky error flags; a new event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err.overflow  <= (p_write_en && w_full)  || (r_err.overflow  && !p_err_clear);
      r_err.underflow <= (p_read_en  && w_empty) || (r_err.underflow && !p_err_clear);
    end
  end

`ifdef SYNC_FIFO_LEVEL_FWFT_EN
  // The output register holds the head entry; the array holds the rest.
  logic           r_out_valid;
  logic [LVL-1:0] w_mem_cnt;
  logic           w_mem_empty;
  logic           w_load;
  logic           w_bypass;

  assign w_mem_cnt   = r_level - {{(LVL-1){1'b0}}, r_out_valid};
  assign w_mem_empty = (w_mem_cnt == '0);
  assign w_load      = !r_out_valid || w_rd_acc;
  // A write that meets an empty array while the output register is being
  // refilled goes straight to the output so empty drops after one cycle.
  assign w_bypass    = w_load && w_mem_empty && w_wr_acc;
  assign w_mem_we    = w_wr_acc && !w_bypass;
  assign w_empty     = !r_out_valid;

  // Refill the output register from the array, or from the write port when
  // the array has nothing buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_rd_data   <= '0;
      r_rd_ptr    <= '0;
    end else if (w_load) begin
      if (!w_mem_empty) begin
        r_out_valid <= 1'b1;
        r_rd_data   <= w_mem_rd_data;
        r_rd_ptr    <= r_rd_ptr + AW'(1);
      end else if (w_wr_acc) begin
        r_out_valid <= 1'b1;
        r_rd_data   <= p_write_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end
`else
  assign w_mem_we = w_wr_acc;
  assign w_empty  = (r_level == '0);

  // Registered read: data updates only on an accepted read and holds after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_rd_ptr  <= '0;
    end else if (w_rd_acc) begin
      r_rd_data <= w_mem_rd_data;
      r_rd_ptr  <= r_rd_ptr + AW'(1);
    end
  end
`endif

  assign p_write_full        = w_full;
  assign p_read_empty        = w_empty;
  assign p_level             = r_level;
  assign p_read_data         = r_rd_data;
  assign p_overflow          = r_err.overflow;
  assign p_underflow         = r_err.underflow;
  // Thresholds above SIZE can never be reached, so almost-full stays low.
  assign p_write_almost_full = level_ge(32'(r_level), 32'(p_af_thresh));
  assign p_read_almost_empty = level_ge(32'(p_ae_thresh), 32'(r_level));

endmodule : sync_fifo_level
`default_nettype wire

// File: tb/tb_sync_fifo_level.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_level
// Description : Self-checking bench for sync_fifo_level (SIZE=4, BITS=8)
//               with a queue scoreboard and a reference occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_level;

  localparam int BITS = 8;
  localparam int SIZE = 4;
  localparam int LVL  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            p_write_en = 1'b0;
  logic [BITS-1:0] p_write_data = '0;
  logic            p_write_full;
  logic            p_write_almost_full;
  logic [LVL-1:0]  p_af_thresh = 3'd3;
  logic            p_read_en = 1'b0;
  logic [BITS-1:0] p_read_data;
  logic            p_read_empty;
  logic            p_read_almost_empty;
  logic [LVL-1:0]  p_ae_thresh = 3'd1;
  logic [LVL-1:0]  p_level;
  logic            p_overflow;
  logic            p_underflow;
  logic            p_err_clear = 1'b0;

  sync_fifo_level #(
    .BITS (BITS),
    .SIZE (SIZE)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .p_write_en          (p_write_en),
    .p_write_data        (p_write_data),
    .p_write_full        (p_write_full),
    .p_write_almost_full (p_write_almost_full),
    .p_af_thresh         (p_af_thresh),
    .p_read_en           (p_read_en),
    .p_read_data         (p_read_data),
    .p_read_empty        (p_read_empty),
    .p_read_almost_empty (p_read_almost_empty),
    .p_ae_thresh         (p_ae_thresh),
    .p_level             (p_level),
    .p_overflow          (p_overflow),
    .p_underflow         (p_underflow),
    .p_err_clear         (p_err_clear)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [BITS-1:0] sb[$];
  int              m_lvl = 0;
  logic            m_ov = 1'b0;
  logic            m_uf = 1'b0;
  logic [BITS-1:0] m_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ":level"},  32'(p_level),             32'(m_lvl));
    check({tag, ":empty"},  32'(p_read_empty),        32'(m_lvl == 0));
    check({tag, ":full"},   32'(p_write_full),        32'(m_lvl == SIZE));
    check({tag, ":afull"},  32'(p_write_almost_full), 32'(m_lvl >= int'(p_af_thresh)));
    check({tag, ":aempty"}, 32'(p_read_almost_empty), 32'(m_lvl <= int'(p_ae_thresh)));
    check({tag, ":ovf"},    32'(p_overflow),          32'(m_ov));
    check({tag, ":udf"},    32'(p_underflow),         32'(m_uf));
`ifdef SYNC_FIFO_LEVEL_FWFT_EN
    if (m_lvl > 0) check({tag, ":head"}, 32'(p_read_data), 32'(sb[0]));
`else
    check({tag, ":rdata"}, 32'(p_read_data), 32'(m_rdata));
`endif
  endtask

  // One clock of stimulus; expectations are derived from the model before
  // the edge and compared #1 after it.
  task automatic step(input logic we, input logic [BITS-1:0] wd, input logic re,
                      input logic clr, input string tag);
    logic wacc;
    logic racc;
    p_write_en   = we;
    p_write_data = wd;
    p_read_en    = re;
    p_err_clear  = clr;
    wacc = we && (m_lvl < SIZE);
    racc = re && (m_lvl > 0);
    m_ov = (we && (m_lvl == SIZE)) || (m_ov && !clr);
    m_uf = (re && (m_lvl == 0))    || (m_uf && !clr);
    if (racc) m_rdata = sb.pop_front();
    if (wacc) sb.push_back(wd);
    m_lvl = m_lvl + int'(wacc) - int'(racc);
    @(posedge clk);
    #1;
    p_write_en  = 1'b0;
    p_read_en   = 1'b0;
    p_err_clear = 1'b0;
    check_state(tag);
  endtask

  task automatic model_reset();
    sb.delete();
    m_lvl   = 0;
    m_ov    = 1'b0;
    m_uf    = 1'b0;
    m_rdata = '0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;

    // Fill A..D, full after D; E dropped and flags overflow
    step(1'b1, 8'hAA, 1'b0, 1'b0, "wrA");
    step(1'b1, 8'hBB, 1'b0, 1'b0, "wrB");
    step(1'b1, 8'hCC, 1'b0, 1'b0, "wrC");
    step(1'b1, 8'hDD, 1'b0, 1'b0, "wrD");
    step(1'b1, 8'hEE, 1'b0, 1'b0, "wrE_drop");
    // Threshold above SIZE keeps almost-full low even when full
    p_af_thresh = 3'd5;
    #1;
    check("af_thresh_gt_size", 32'(p_write_almost_full), 32'd0);
    p_af_thresh = 3'd3;
    #1;
    step(1'b0, 8'h00, 1'b1, 1'b0, "rdA");
    step(1'b0, 8'h00, 1'b1, 1'b0, "rdB");
    step(1'b0, 8'h00, 1'b1, 1'b0, "rdC");
    step(1'b0, 8'h00, 1'b1, 1'b0, "rdD");

    // Underflow on empty, set beats clear, then clear
    step(1'b0, 8'h00, 1'b1, 1'b0, "udf_set");
    step(1'b0, 8'h00, 1'b1, 1'b1, "udf_set_vs_clr");
    step(1'b0, 8'h00, 1'b0, 1'b1, "err_clear");

    // Level 2, then 10 cycles of simultaneous write+read with wrap
    step(1'b1, 8'h10, 1'b0, 1'b0, "pre1");
    step(1'b1, 8'h11, 1'b0, 1'b0, "pre2");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, BITS'(8'h20 + i), 1'b1, 1'b0, "wr_rd");
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, "drain1");
    step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");

    // Reset mid-burst at level 3
    step(1'b1, 8'h31, 1'b0, 1'b0, "burst1");
    step(1'b1, 8'h32, 1'b0, 1'b0, "burst2");
    step(1'b1, 8'h33, 1'b0, 1'b0, "burst3");
    p_write_en   = 1'b1;
    p_write_data = 8'h34;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(posedge clk);
    #1;
    p_write_en = 1'b0;
    rst_n = 1'b1;
    #1;
    step(1'b1, 8'h5A, 1'b0, 1'b0, "post_rst_wr");
    step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_rd");

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), BITS'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sync_fifo_level
`default_nettype wire

// File: doc/sync_fifo_level.md
SYNC_FIFO_LEVEL -- requirements
Module: sync_fifo_level

Interface
REQ-001 SHALL have parameter BITS, default 32: entry width in bits, >=1.
REQ-002 SHALL have parameter SIZE, default 16: entry count, power of two, >=2; LVL = $clog2(SIZE)+1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port p_write_en  input  1  write request.
REQ-006 SHALL have port p_write_data  input  BITS  write data.
REQ-007 SHALL have port p_write_full  output  1  full flag.
REQ-008 SHALL have port p_write_almost_full  output  1  level >= p_af_thresh.
REQ-009 SHALL have port p_af_thresh  input  LVL  almost-full threshold (quasi-static).
REQ-010 SHALL have port p_read_en  input  1  read request.
REQ-011 SHALL have port p_read_data  output  BITS  read data.
REQ-012 SHALL have port p_read_empty  output  1  empty flag.
REQ-013 SHALL have port p_read_almost_empty  output  1  level <= p_ae_thresh.
REQ-014 SHALL have port p_ae_thresh  input  LVL  almost-empty threshold (quasi-static).
REQ-015 SHALL have port p_level  output  LVL  current occupancy, 0..SIZE.
REQ-016 SHALL have port p_overflow  output  1  sticky: write attempted while full.
REQ-017 SHALL have port p_underflow  output  1  sticky: read attempted while empty.
REQ-018 SHALL have port p_err_clear  input  1  clears both sticky flags.

Function
REQ-019 Write SHALL be accepted iff p_write_en && !p_write_full; data stored at write pointer, pointer +1 mod SIZE.
REQ-020 Read SHALL be accepted iff p_read_en && !p_read_empty; read pointer +1 mod SIZE.
REQ-021 Occupancy SHALL be a registered LVL-bit counter: +1 write only, -1 read only, unchanged on both or neither.
REQ-022 Simultaneous accepted write and read SHALL work at any level, including wrap-around of both pointers.
REQ-023 Full = (level == SIZE); write attempted while full SHALL be dropped, no state change except p_overflow.
REQ-024 Almost-full/almost-empty SHALL be unsigned compares of registered level; thresholds > SIZE SHALL leave almost-full permanently low.
REQ-025 All flags and p_level SHALL derive from registers only; no combinational path from p_*_en to any output.
REQ-026 Sticky flag set SHALL take priority over p_err_clear in the same cycle.
REQ-027 Empty SHALL deassert exactly 1 cycle after the first accepted write into an empty FIFO; full SHALL assert 1 cycle after the SIZE-th write.

Reset
REQ-028 On rst_n low: pointers, level, p_overflow, p_underflow, p_read_data = 0; p_read_empty = 1; p_read_almost_empty = 1; p_write_full = 0; storage array not reset.
REQ-029 Reset assertion mid-operation SHALL discard all contents immediately; first accepted write after release is read first.

Configuration
REQ-030 Macro SYNC_FIFO_LEVEL_FWFT_EN SHALL select read mode.
REQ-031 Without macro: p_read_data SHALL update 1 cycle after accepted read and hold otherwise; p_read_empty = (level == 0).
REQ-032 With macro: first-word-fall-through; p_read_data SHALL present head entry from an output register while p_read_empty = 0; accepted read presents next entry next cycle; total capacity stays SIZE, p_level counts output register; REQ-027 timing unchanged.

Structure
REQ-033 Package fifo_pkg SHALL hold the fifo_err_t packed struct {overflow, underflow} and the shared level-compare helper function.
REQ-034 Storage SHALL be sub-module fifo_mem (1 write port, 1 registered or async read port, parameters BITS, SIZE).

Verification
REQ-035 SIZE=4: write A,B,C,D -> full=1 cycle after D, level=4; 5th write E -> dropped, p_overflow=1; reads return A,B,C,D.
REQ-036 Empty FIFO, read_en=1 -> p_underflow=1, level stays 0; p_err_clear=1 next cycle -> flag 0.
REQ-037 Level 2, write+read same cycle for 10 cycles -> level stays 2, pointers wrap, data order preserved.
REQ-038 af_thresh=3, ae_thresh=1: fill 0->4 -> almost_empty high at 0,1, almost_full high at 3,4.
REQ-039 Level 3, rst_n pulsed low mid-burst -> empty=1, level=0 asynchronously; next write X read back as X.
REQ-040 FWFT build: write 0x55 into empty -> next cycle empty=0, p_read_data=0x55 without read_en.
